// File: rtl/gen_gamma_pkg.sv
// Shared definitions for the gamma encoder/decoder pair: FSM states, default
// LCG constants and the gamma recurrence both sides must agree on.
package gen_gamma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } gg_state_t;

    localparam int unsigned LCG_A_DEFAULT = 32'd5;
    localparam int unsigned LCG_C_DEFAULT = 32'd3;

    // Computed at 32 bits; callers truncate to their word width, which yields
    // the recurrence modulo 2^SIZE for any SIZE up to 32.
    function automatic logic [31:0] lcg_next(
        input logic [31:0] gamma,
        input logic [31:0] a,
        input logic [31:0] c
    );
        return gamma * a + c;
    endfunction

endpackage

// File: rtl/gen_gamma_encoder_lcg.sv
// Gamma generator: a SIZE-bit LCG state register with key load, advance
// enable and synchronous reset. Load takes priority over advance.
module gamma_lcg
    import gen_gamma_pkg::*;
#(
    parameter int          SIZE  = 8,
    parameter int unsigned LCG_A = LCG_A_DEFAULT,
    parameter int unsigned LCG_C = LCG_C_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [SIZE-1:0] nk_i,
    input  logic            adv_i,
    output logic [SIZE-1:0] gamma_o
);

    logic [SIZE-1:0] gamma_q;
    logic [SIZE-1:0] gamma_d;

    always_comb begin
        gamma_d = gamma_q;
        if (load_i) begin
            gamma_d = nk_i;
        end else if (adv_i) begin
            gamma_d = SIZE'(lcg_next(32'(gamma_q), 32'(LCG_A), 32'(LCG_C)));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gamma_q <= '0;
        end else begin
            gamma_q <= gamma_d;
        end
    end

    assign gamma_o = gamma_q;

endmodule

// File: rtl/gen_gamma_encoder.sv
// Gamma encoder: md = id + gamma with a one-word output register and
// valid/ready on both sides. Define GEN_GAMMA_ENC_CNT_EN to add word_cnt.
module gen_gamma_encoder
    import gen_gamma_pkg::*;
#(
    parameter int          SIZE  = 8,
    parameter int unsigned LCG_A = LCG_A_DEFAULT,
    parameter int unsigned LCG_C = LCG_C_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set0,
    input  logic            set1,
    input  logic [SIZE-1:0] nk,
    input  logic [SIZE-1:0] id,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [SIZE:0]   md,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
`ifdef GEN_GAMMA_ENC_CNT_EN
    ,
    output logic [15:0]     word_cnt
`endif
);

    gg_state_t       state_q;
    gg_state_t       state_d;
    logic [SIZE:0]   md_q;
    logic [SIZE:0]   md_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic [SIZE-1:0] gamma;
    logic            accept;

    gamma_lcg #(
        .SIZE  (SIZE),
        .LCG_A (LCG_A),
        .LCG_C (LCG_C)
    ) u_lcg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (set0),
        .nk_i    (nk),
        .adv_i   (accept),
        .gamma_o (gamma)
    );

    // set0 rekeys from any state; set1 only starts the stream from ARMED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (set0) state_d = ARMED;
            end
            ARMED: begin
                if (!set0 && set1) state_d = RUN;
            end
            RUN: begin
                if (set0) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    // A rekey on the same edge wins, so a word offered alongside set0 is dropped.
    assign accept   = in_valid && in_ready && !set0;

    always_comb begin
        md_d        = md_q;
        out_valid_d = out_valid_q;
        if (set0) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            md_d        = {1'b0, id} + {1'b0, gamma};
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            md_q        <= md_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign md        = md_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RUN);

`ifdef GEN_GAMMA_ENC_CNT_EN
    logic [15:0] word_cnt_q;
    logic [15:0] word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (set0) begin
            word_cnt_d = '0;
        end else if (accept) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_gen_gamma_encoder.sv
// Self-checking bench for gen_gamma_encoder: directed vector table, then
// randomized traffic against a behavioural model of the encoder.
module tb_gen_gamma_encoder;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       set0;
    logic       set1;
    logic [7:0] nk;
    logic [7:0] id;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] md;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef GEN_GAMMA_ENC_CNT_EN
    logic [15:0] word_cnt;
`endif

    int nVectors = 0;
    int nMiss    = 0;

    int mState = M_IDLE;
    int mGamma = 0;
    int mMd    = 0;
    int mValid = 0;
    int mCnt   = 0;

    typedef struct {
        logic       r;
        logic       s0;
        logic       s1;
        logic [7:0] k;
        logic [7:0] d;
        logic       iv;
        logic       ordy;
        logic       xRdy;
        logic [8:0] xMd;
        logic       xOv;
        logic       xBusy;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    gen_gamma_encoder #(.SIZE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .set0      (set0),
        .set1      (set1),
        .nk        (nk),
        .id        (id),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .md        (md),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef GEN_GAMMA_ENC_CNT_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s0, input logic s1, input logic [7:0] k,
                                 input logic [7:0] d, input logic iv, input logic ordy);
        rst       = r;
        set0      = s0;
        set1      = s1;
        nk        = k;
        id        = d;
        in_valid  = iv;
        out_ready = ordy;
        #1;
    endtask

    function automatic int modelReady();
        return (mState == M_RUN && (mValid == 0 || out_ready)) ? 1 : 0;
    endfunction

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int rdy;
        rdy = modelReady();
        if (rst) begin
            mState = M_IDLE; mGamma = 0; mMd = 0; mValid = 0; mCnt = 0;
        end else if (set0) begin
            mState = M_ARMED; mGamma = int'(nk); mValid = 0; mCnt = 0;
        end else begin
            if (mState == M_ARMED && set1) mState = M_RUN;
            if (in_valid && rdy == 1) begin
                mMd    = int'(id) + mGamma;
                mValid = 1;
                mGamma = (5 * mGamma + 3) % 256;
                mCnt   = (mCnt + 1) % 65536;
            end else if (mValid == 1 && out_ready) begin
                mValid = 0;
            end
        end
    endtask

    task automatic clockEdge();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".md"}, 32'(md), 32'(mMd));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(mValid));
        checkOutput({tag, ".busy"}, 32'(busy), (mState == M_RUN) ? 32'd1 : 32'd0);
`ifdef GEN_GAMMA_ENC_CNT_EN
        checkOutput({tag, ".word_cnt"}, 32'(word_cnt), 32'(mCnt));
`endif
    endtask

    initial begin
        //          r   s0  s1  nk     id     iv  ordy  rdy  md      ov  busy
        vecs[0]  = '{0, 0,  1,  8'h00, 8'h00, 0,  0,    0,   9'h000, 0,  0};
        vecs[1]  = '{0, 1,  0,  8'h10, 8'h00, 0,  0,    0,   9'h000, 0,  0};
        vecs[2]  = '{0, 0,  1,  8'h00, 8'h00, 0,  0,    0,   9'h000, 0,  1};
        vecs[3]  = '{0, 0,  0,  8'h00, 8'h01, 1,  1,    1,   9'h011, 1,  1};
        vecs[4]  = '{0, 0,  0,  8'h00, 8'h01, 1,  1,    1,   9'h054, 1,  1};
        vecs[5]  = '{0, 0,  0,  8'h00, 8'h00, 0,  1,    1,   9'h054, 0,  1};
        vecs[6]  = '{0, 0,  0,  8'h00, 8'h05, 1,  0,    1,   9'h0A7, 1,  1};
        vecs[7]  = '{0, 0,  0,  8'h00, 8'h07, 1,  0,    0,   9'h0A7, 1,  1};
        vecs[8]  = '{0, 0,  0,  8'h00, 8'h07, 1,  0,    0,   9'h0A7, 1,  1};
        vecs[9]  = '{0, 0,  0,  8'h00, 8'h07, 1,  0,    0,   9'h0A7, 1,  1};
        vecs[10] = '{0, 0,  0,  8'h00, 8'h07, 1,  1,    1,   9'h034, 1,  1};
        vecs[11] = '{0, 1,  0,  8'hF0, 8'h00, 0,  0,    0,   9'h034, 0,  0};
        vecs[12] = '{0, 1,  1,  8'hF0, 8'h00, 0,  0,    0,   9'h034, 0,  0};
        vecs[13] = '{0, 0,  1,  8'h00, 8'h00, 0,  0,    0,   9'h034, 0,  1};
        vecs[14] = '{0, 0,  0,  8'h00, 8'h20, 1,  1,    1,   9'h110, 1,  1};
        vecs[15] = '{1, 0,  0,  8'h00, 8'h33, 1,  0,    0,   9'h000, 0,  0};
        vecs[16] = '{0, 0,  1,  8'h00, 8'h00, 0,  0,    0,   9'h000, 0,  0};

        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0);
        clockEdge();
        clockEdge();
        checkOutput("reset.md", 32'(md), 32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].r, vecs[i].s0, vecs[i].s1, vecs[i].k, vecs[i].d, vecs[i].iv, vecs[i].ordy);
            checkOutput($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].xRdy));
            clockEdge();
            checkOutput($sformatf("vec%0d.md", i), 32'(md), 32'(vecs[i].xMd));
            checkOutput($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].xOv));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].xBusy));
        end

`ifdef GEN_GAMMA_ENC_CNT_EN
        applyStimulus(0, 1, 0, 8'h42, 8'h00, 0, 1);
        clockEdge();
        applyStimulus(0, 0, 1, 8'h00, 8'h00, 0, 1);
        clockEdge();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 8'(i), 1, 1);
            clockEdge();
        end
        applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 1);
        clockEdge();
        checkOutput("cnt.after5", 32'(word_cnt), 32'd5);
        applyStimulus(0, 1, 0, 8'h11, 8'h00, 0, 1);
        clockEdge();
        checkOutput("cnt.cleared", 32'(word_cnt), 32'd0);
`endif

        applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0);
        clockEdge();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 31) == 0),
                          ($urandom_range(0, 7) == 0),
                          8'($urandom),
                          8'($urandom),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) != 0));
            checkOutput($sformatf("rnd%0d.in_ready", cyc), 32'(in_ready), 32'(modelReady()));
            clockEdge();
            checkAgainstModel($sformatf("rnd%0d", cyc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
